// File: rtl/tri_buffer_pkg.sv
// rtl/tri_buffer_pkg.sv - shared types and select decode for the triple-buffer SRAM arbiter
//
// Contents:
//   bank_t       physical bank ids X/Y/Z (upper two SRAM address bits)
//   sel_t        buffer-selection codes A..F from the triple-buffer controller
//   state_t      arbiter FSM states
//   bank_pair_t  decoded {cap_bank, tx_bank, valid}
//   sel_to_banks maps a select code to the capture and transmission banks
package tri_buffer_pkg;

    typedef enum logic [1:0] {
        BANK_X = 2'b00,
        BANK_Y = 2'b01,
        BANK_Z = 2'b10
    } bank_t;

    typedef enum logic [2:0] {
        SEL_A = 3'd0,
        SEL_B = 3'd1,
        SEL_C = 3'd2,
        SEL_D = 3'd3,
        SEL_E = 3'd4,
        SEL_F = 3'd5
    } sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_TURN
    } state_t;

    typedef struct packed {
        bank_t cap_bank;
        bank_t tx_bank;
        logic  valid;
    } bank_pair_t;

    // Codes 6 and 7 decode to valid=0; the bank fields are then don't-care.
    function automatic bank_pair_t sel_to_banks(input logic [2:0] sel);
        bank_pair_t r;
        r = '{cap_bank: BANK_X, tx_bank: BANK_X, valid: 1'b0};
        case (sel)
            SEL_A:   r = '{cap_bank: BANK_X, tx_bank: BANK_Y, valid: 1'b1};
            SEL_B:   r = '{cap_bank: BANK_X, tx_bank: BANK_Z, valid: 1'b1};
            SEL_C:   r = '{cap_bank: BANK_Y, tx_bank: BANK_X, valid: 1'b1};
            SEL_D:   r = '{cap_bank: BANK_Y, tx_bank: BANK_Z, valid: 1'b1};
            SEL_E:   r = '{cap_bank: BANK_Z, tx_bank: BANK_X, valid: 1'b1};
            SEL_F:   r = '{cap_bank: BANK_Z, tx_bank: BANK_Y, valid: 1'b1};
            default: r = '{cap_bank: BANK_X, tx_bank: BANK_X, valid: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tri_rd_pipe.sv
// rtl/tri_rd_pipe.sv - read-valid tracking pipeline and read data capture
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset (flushes in-flight reads)
//   issue        a read was granted this cycle
//   sram_rdata   raw SRAM read data
//   rvalid       one-cycle pulse qualifying rdata
//   rdata        captured read data
module tri_rd_pipe
    import tri_buffer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // vld[0] lines up with the SRAM strobe cycle; vld[READ_LAT] with the
    // cycle in which the SRAM drives the requested word.
    logic [READ_LAT:0] vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            vld    <= {vld[READ_LAT-1:0], issue};
            rvalid <= vld[READ_LAT];
            if (vld[READ_LAT]) begin
                rdata <= sram_rdata;
            end
        end
    end

endmodule

// File: rtl/tri_sram_arbiter.sv
// rtl/tri_sram_arbiter.sv - round-robin capture/transmit arbiter for a three-bank single-port SRAM
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   sram_select                 triple-buffer code A=0..F=5 (6,7 invalid)
//   cap_req/addr/wdata/gnt      capture write request channel
//   tx_req/addr/gnt             transmission read request channel
//   tx_rdata, tx_rvalid         read return, READ_LAT+2 cycles after tx_gnt
//   sram_en/we/addr/wdata/rdata registered SRAM port, addr = {bank, word}
//   sel_error                   registered flag, high while sram_select is invalid
//
// Build option: define TRI_ARB_TURNAROUND_EN to insert one dead SRAM cycle
// (TURN state) on every read/write direction change.
module tri_sram_arbiter
    import tri_buffer_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        sram_select,
    input  logic              cap_req,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_wdata,
    output logic              cap_gnt,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_gnt,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              tx_rvalid,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W+1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sel_error
);

    state_t     state, state_nxt;
    logic       last_tx;              // 1: transmission was granted last
    logic       turn_tx, turn_tx_nxt; // direction pending across TURN
    logic       want_tx;
    logic       turn_needed;
    bank_pair_t banks;

    assign banks = sel_to_banks(sram_select);

    // On a tie the requester that was not granted last wins.
    assign want_tx = tx_req && (!cap_req || !last_tx);

    always_comb begin
        cap_gnt     = 1'b0;
        tx_gnt      = 1'b0;
        state_nxt   = ST_IDLE;
        turn_tx_nxt = turn_tx;
`ifdef TRI_ARB_TURNAROUND_EN
        turn_needed = (state == ST_WRITE && want_tx) ||
                      (state == ST_READ  && !want_tx);
`else
        turn_needed = 1'b0;
`endif
        // An invalid select blocks all grants and parks the FSM in IDLE.
        if (banks.valid) begin
            case (state)
                ST_TURN: begin
                    cap_gnt   = !turn_tx && cap_req;
                    tx_gnt    = turn_tx && tx_req;
                    state_nxt = turn_tx ? ST_READ : ST_WRITE;
                end
                default: begin
                    if (cap_req || tx_req) begin
                        if (turn_needed) begin
                            state_nxt   = ST_TURN;
                            turn_tx_nxt = want_tx;
                        end else begin
                            cap_gnt   = !want_tx;
                            tx_gnt    = want_tx;
                            state_nxt = want_tx ? ST_READ : ST_WRITE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_tx    <= 1'b1;
            turn_tx    <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sel_error  <= 1'b0;
        end else begin
            state     <= state_nxt;
            turn_tx   <= turn_tx_nxt;
            sel_error <= !banks.valid;
            sram_en   <= cap_gnt || tx_gnt;
            sram_we   <= cap_gnt;
            if (cap_gnt || tx_gnt) begin
                last_tx <= tx_gnt;
            end
            // Address and write data hold their last value on idle cycles.
            if (cap_gnt) begin
                sram_addr  <= {banks.cap_bank, cap_addr};
                sram_wdata <= cap_wdata;
            end else if (tx_gnt) begin
                sram_addr  <= {banks.tx_bank, tx_addr};
            end
        end
    end

    tri_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .issue      (tx_gnt),
        .sram_rdata (sram_rdata),
        .rvalid     (tx_rvalid),
        .rdata      (tx_rdata)
    );

endmodule

// File: doc/tri_sram_arbiter.md
# tri_sram_arbiter

Shares one single-port SRAM, split into three equal banks (X, Y, Z), between the capture writer and the transmission reader of the UART triple-buffer datapath. Each accepted access is steered to the bank that the triple-buffer controller's `sram_select` code assigns to its requester. Capture and transmission are arbitrated round-robin, with a bus-turnaround cycle on direction changes. Reads return data through a fixed-latency pipeline.

## Interface
- `ADDR_W`, 16: per-bank word address width. The physical SRAM address is ADDR_W+2 bits.
- `DATA_W`, 8: data width.
- `READ_LAT`, 2: SRAM read latency in cycles. Legal range is 1–8.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sram_select`  in  3  buffer-selection code: A=0…F=5; 6 and 7 are invalid.
- `cap_req`  in  1  capture write request; held with `cap_addr`/`cap_wdata` until granted.
- `cap_addr`  in  ADDR_W  capture word address.
- `cap_wdata`  in  DATA_W  capture write data.
- `cap_gnt`  out  1  write accepted this cycle.
- `tx_req`  in  1  transmission read request; held with `tx_addr` until granted.
- `tx_addr`  in  ADDR_W  transmission word address.
- `tx_gnt`  out  1  read accepted this cycle.
- `tx_rdata`  out  DATA_W  read data.
- `tx_rvalid`  out  1  one-cycle pulse qualifying `tx_rdata`.
- `sram_en`, `sram_we`  out  1  SRAM strobe and write enable.
- `sram_addr`  out  ADDR_W+2  {bank[1:0], word}. Bank encoding: X=00, Y=01, Z=10.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data.
- `sel_error`  out  1  registered flag; high while `sram_select` is invalid.

## Operation
Select decode (capture bank / transmission bank):
- A = X/Y, B = X/Z, C = Y/X, D = Y/Z, E = Z/X, F = Z/Y.
- The bank is resolved from `sram_select` in the grant cycle. In-flight reads keep the bank they were issued with.

Handshake:
- `cap_gnt`/`tx_gnt` are combinational from req, FSM state and priority pointer.
- A transfer occurs on the rising edge that ends a cycle with req=gnt=1.
- At most one grant per cycle.
- No grants while `sram_select` is invalid.

Arbitration:
- When only one requester is active and the FSM allows, it is granted.
- When both are active, the requester that is not the last-granted one wins.
- The last-granted pointer resets to "tx", so capture wins the first tie.

FSM states are IDLE, WRITE, READ and TURN:
- IDLE→WRITE on a cap grant; IDLE→READ on a tx grant.
- WRITE/READ: a same-direction grant stays in the state. A grant in the opposite direction is refused; the FSM goes to TURN for one cycle with no grant, then takes that grant.
- With no request, WRITE/READ go to IDLE.
- TURN always advances next cycle to the direction chosen when it was entered.

Read pipeline:
- A READ_LAT+1 deep valid shift register tracks each read.
- `sram_rdata` is captured into `tx_rdata` when the tracked read reaches the end of the pipeline.

Outputs:
- `sram_en`/`sram_we`/`sram_addr`/`sram_wdata` are registered.
- On an idle cycle, `sram_en` is 0 and addr/wdata hold their previous values.

Reset (asynchronous, any time):
- All outputs go to 0, the FSM to IDLE, and the pointer to tx.
- The read pipeline is flushed, so no `tx_rvalid` appears for reads issued before reset.

## Timing
- Grant at cycle t: SRAM strobe visible in t+1, write complete at the end of t+1.
- Read: `sram_rdata` valid in t+1+READ_LAT; `tx_rvalid`/`tx_rdata` in t+2+READ_LAT. Grant-to-data latency is READ_LAT+2.
- Same-direction back-to-back accesses run at one per cycle.
- A direction change costs one dead cycle, provided `TRI_ARB_TURNAROUND_EN` is defined.
- `sel_error` rises one cycle after `sram_select` becomes invalid and falls one cycle after it becomes valid.

## Configuration
- `TRI_ARB_TURNAROUND_EN` defined: the TURN state exists; a direction change inserts exactly one idle SRAM cycle.
- `TRI_ARB_TURNAROUND_EN` undefined: TURN is removed; the opposite-direction winner is granted immediately, so reads and writes may alternate every cycle.

## Structure
- Package `tri_buffer_pkg` holds:
  - bank ids X/Y/Z;
  - select codes A–F;
  - the FSM state enum;
  - the function `sel_to_banks(sel) → {cap_bank, tx_bank, valid}`.
- Sub-module `tri_rd_pipe` holds the READ_LAT-parameterised valid shift register and the data capture, with a flush on reset.

## Test plan
1. `sram_select`=A, both requests held, cap_addr=0x0010, tx_addr=0x0020, turnaround enabled: `cap_gnt` at t → `sram_addr`=0x00010 with we=1 at t+1; no grant at t+1; `tx_gnt` at t+2 → `sram_addr`=0x10020 with we=0 at t+3.
2. READ_LAT=2, single tx read, SRAM model returns 0xA5: `tx_rvalid`=1 with `tx_rdata`=0xA5 exactly at grant+4, for one cycle.
3. `cap_req` held for 4 cycles with sel=D: 4 consecutive `cap_gnt` cycles; `sram_addr` bank=01 each time; no dead cycles.
4. sel changes D→E between two writes: first write uses bank 01, second uses bank 10.
5. sel=6 with both requests: `sel_error`=1 the next cycle, no grants, `sram_en`=0; sel=A restores grants.
6. `reset` pulsed one cycle after a tx grant: outputs go to 0 immediately and no `tx_rvalid` is produced afterwards.
